car_traffic: RTL and testbench

//  Generates horizontal positions of the 8 traffic cars that the player logic reads for collision checks and the renderer draws.

---
 rtl/car_traffic_pkg.sv | 63 ++++++
 rtl/car_traffic_lane_mover.sv | 85 ++++++++
 rtl/car_traffic.sv | 130 +++++++++++++
 tb/tb_car_traffic.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/car_traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : car_traffic_pkg
// Description : Shared game geometry and lane constants used by the car
//               traffic generator, the player control and the VGA renderer.
//               Holds screen size, car sprite size, lane rows, start columns,
//               lane direction encoding and the lane period helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package car_traffic_pkg;

    // Screen and sprite geometry
    localparam int GAME_H_DISPLAY  = 640;
    localparam int GAME_V_DISPLAY  = 480;
    localparam int GAME_CAR_WIDTH  = 32;
    localparam int GAME_CAR_HEIGHT = 32;

    // Lane rows (top edge of each car sprite)
    localparam logic [9:0] GAME_CAR_Y1 = 10'd64;
    localparam logic [9:0] GAME_CAR_Y2 = 10'd112;
    localparam logic [9:0] GAME_CAR_Y3 = 10'd160;
    localparam logic [9:0] GAME_CAR_Y4 = 10'd208;
    localparam logic [9:0] GAME_CAR_Y5 = 10'd256;
    localparam logic [9:0] GAME_CAR_Y6 = 10'd304;
    localparam logic [9:0] GAME_CAR_Y7 = 10'd352;
    localparam logic [9:0] GAME_CAR_Y8 = 10'd400;

    // Start columns, staggered so lanes do not line up at game start
    localparam logic [9:0] GAME_INIT_X1 = 10'd0;
    localparam logic [9:0] GAME_INIT_X2 = 10'd608;
    localparam logic [9:0] GAME_INIT_X3 = 10'd96;
    localparam logic [9:0] GAME_INIT_X4 = 10'd500;
    localparam logic [9:0] GAME_INIT_X5 = 10'd200;
    localparam logic [9:0] GAME_INIT_X6 = 10'd350;
    localparam logic [9:0] GAME_INIT_X7 = 10'd420;
    localparam logic [9:0] GAME_INIT_X8 = 10'd64;

    // Lane travel direction
    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    // Lane tick period for a level: base minus per-level reduction, floored.
    // The comparison form avoids an unsigned wrap when the reduction exceeds
    // the base period.
    function automatic logic [31:0] lane_period(
        input logic [3:0]  lvl,
        input logic [31:0] base,
        input logic [31:0] step,
        input logic [31:0] floor_p
    );
        logic [31:0] reduction;
        reduction = {28'd0, lvl} * step;
        if (reduction >= (base - floor_p)) begin
            return floor_p;
        end
        return base - reduction;
    endfunction

endpackage : car_traffic_pkg
`default_nettype wire

// File: rtl/car_traffic_lane_mover.sv
`default_nettype none
// ============================================================================
// Module      : lane_mover
// Description : One traffic lane: a tick divider plus the car position
//               register with wrap at the screen edge.
// Ports       : CLK    - system clock
//               RST_N  - asynchronous active-low reset
//               clear  - synchronous return to start state (game restart)
//               run    - divider advances while high, holds while low
//               period - clocks per tick, sampled at every tick reload
//               x      - car left-edge column, registered
// Revision    : 1.0 - initial release
// ============================================================================
module lane_mover
    import car_traffic_pkg::*;
#(
    parameter dir_e        DIR          = DIR_RIGHT,
    parameter logic [9:0]  INIT_X       = 10'd0,
    parameter int          STEP         = 2,
    parameter int          H_DISPLAY    = GAME_H_DISPLAY,
    parameter int          CAR_WIDTH    = GAME_CAR_WIDTH,
    parameter logic [31:0] RESET_PERIOD = 32'd400000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] period,
    output logic [9:0]  x
);

    localparam logic [10:0] C_X_MAX = 11'(H_DISPLAY - CAR_WIDTH);
    localparam logic [10:0] C_STEP  = 11'(STEP);

    logic [31:0] r_cnt;
    logic [31:0] r_period;   // period in force for the current count
    logic [9:0]  r_x;
    logic        w_tick;
    logic [10:0] w_x_ext;
    logic [9:0]  w_x_next;

    assign w_tick = run && (r_cnt == (r_period - 32'd1));

    // Wrap decisions are made on an 11-bit copy so neither direction can
    // produce a 10-bit overflow or underflow.
    always_comb begin
        w_x_ext  = {1'b0, r_x};
        w_x_next = r_x;
        if (DIR == DIR_RIGHT) begin
            if ((w_x_ext + C_STEP) > C_X_MAX) begin
                w_x_next = 10'd0;
            end else begin
                w_x_next = 10'(w_x_ext + C_STEP);
            end
        end else begin
            if (w_x_ext < C_STEP) begin
                w_x_next = C_X_MAX[9:0];
            end else begin
                w_x_next = 10'(w_x_ext - C_STEP);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt    <= 32'd0;
            r_period <= RESET_PERIOD;
            r_x      <= INIT_X;
        end else if (clear) begin
            r_cnt    <= 32'd0;
            r_period <= RESET_PERIOD;
            r_x      <= INIT_X;
        end else if (w_tick) begin
            r_cnt    <= 32'd0;
            r_period <= period;
            r_x      <= w_x_next;
        end else if (run) begin
            r_cnt    <= r_cnt + 32'd1;
        end
    end

    assign x = r_x;

endmodule : lane_mover
`default_nettype wire

// File: rtl/car_traffic.sv
`default_nettype none
// ============================================================================
// Module      : car_traffic
// Description : Horizontal positions of the 8 traffic cars. Holds the game
//               level, the level-dependent lane period and the post-hit
//               pause counter; one lane_mover per lane.
// Ports       : CLK            - system clock
//               RST_N          - asynchronous active-low reset
//               score_pulse    - player completed a crossing (1 clk)
//               hit_pulse      - player collided (1 clk)
//               game_reset     - restart game (1 clk)
//               car_x1..car_x8 - car left-edge columns, registered
//               level          - current level 0..MAX_LEVEL
//               paused         - high while the post-hit freeze is active
// Revision    : 1.0 - initial release
// ============================================================================
module car_traffic
    import car_traffic_pkg::*;
#(
    parameter int         H_DISPLAY   = GAME_H_DISPLAY,
    parameter int         CAR_WIDTH   = GAME_CAR_WIDTH,
    parameter int         STEP        = 2,
    parameter int         BASE_PERIOD = 400000,
    parameter int         LEVEL_STEP  = 30000,
    parameter int         MIN_PERIOD  = 100000,
    parameter int         MAX_LEVEL   = 9,
    parameter int         HIT_PAUSE   = 25000000,
    parameter logic [9:0] INIT_X1     = GAME_INIT_X1,
    parameter logic [9:0] INIT_X2     = GAME_INIT_X2,
    parameter logic [9:0] INIT_X3     = GAME_INIT_X3,
    parameter logic [9:0] INIT_X4     = GAME_INIT_X4,
    parameter logic [9:0] INIT_X5     = GAME_INIT_X5,
    parameter logic [9:0] INIT_X6     = GAME_INIT_X6,
    parameter logic [9:0] INIT_X7     = GAME_INIT_X7,
    parameter logic [9:0] INIT_X8     = GAME_INIT_X8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       score_pulse,
    input  logic       hit_pulse,
    input  logic       game_reset,
    output logic [9:0] car_x1,
    output logic [9:0] car_x2,
    output logic [9:0] car_x3,
    output logic [9:0] car_x4,
    output logic [9:0] car_x5,
    output logic [9:0] car_x6,
    output logic [9:0] car_x7,
    output logic [9:0] car_x8,
    output logic [3:0] level,
    output logic       paused
);

    localparam logic [31:0] C_BASE_PERIOD = 32'(BASE_PERIOD);
    localparam logic [31:0] C_LEVEL_STEP  = 32'(LEVEL_STEP);
    localparam logic [31:0] C_MIN_PERIOD  = 32'(MIN_PERIOD);
    localparam logic [31:0] C_HIT_RELOAD  = 32'(HIT_PAUSE - 1);
    localparam logic [3:0]  C_MAX_LEVEL   = 4'(MAX_LEVEL);
    localparam logic [9:0]  C_INIT_X [8]  = '{INIT_X1, INIT_X2, INIT_X3, INIT_X4,
                                              INIT_X5, INIT_X6, INIT_X7, INIT_X8};

    logic [3:0]  r_level;
    logic        r_paused;
    logic [31:0] r_pause_cnt;
    logic [31:0] w_period;
    logic [9:0]  w_car_x [8];

    assign w_period = lane_period(r_level, C_BASE_PERIOD, C_LEVEL_STEP, C_MIN_PERIOD);

    // Level and pause share one block so game_reset priority is in one place.
    // A hit and a score in the same cycle both take effect.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_level     <= 4'd0;
            r_paused    <= 1'b0;
            r_pause_cnt <= 32'd0;
        end else if (game_reset) begin
            r_level     <= 4'd0;
            r_paused    <= 1'b0;
            r_pause_cnt <= 32'd0;
        end else begin
            if (score_pulse && (r_level < C_MAX_LEVEL)) begin
                r_level <= r_level + 4'd1;
            end
            // A hit during a pause simply reloads, extending the freeze.
            if (hit_pulse) begin
                r_paused    <= 1'b1;
                r_pause_cnt <= C_HIT_RELOAD;
            end else if (r_paused) begin
                if (r_pause_cnt == 32'd0) begin
                    r_paused <= 1'b0;
                end else begin
                    r_pause_cnt <= r_pause_cnt - 32'd1;
                end
            end
        end
    end

    // Lanes 1,3,5,7 (even index) travel right, lanes 2,4,6,8 travel left.
    for (genvar i = 0; i < 8; i++) begin : g_lane
        lane_mover #(
            .DIR          ((i % 2 == 0) ? DIR_RIGHT : DIR_LEFT),
            .INIT_X       (C_INIT_X[i]),
            .STEP         (STEP),
            .H_DISPLAY    (H_DISPLAY),
            .CAR_WIDTH    (CAR_WIDTH),
            .RESET_PERIOD (C_BASE_PERIOD)
        ) u_lane (
            .CLK    (CLK),
            .RST_N  (RST_N),
            .clear  (game_reset),
            .run    (!r_paused),
            .period (w_period),
            .x      (w_car_x[i])
        );
    end

    assign car_x1 = w_car_x[0];
    assign car_x2 = w_car_x[1];
    assign car_x3 = w_car_x[2];
    assign car_x4 = w_car_x[3];
    assign car_x5 = w_car_x[4];
    assign car_x6 = w_car_x[5];
    assign car_x7 = w_car_x[6];
    assign car_x8 = w_car_x[7];
    assign level  = r_level;
    assign paused = r_paused;

endmodule : car_traffic
`default_nettype wire

// File: tb/tb_car_traffic.sv
`default_nettype none
// ============================================================================
// Module      : tb_car_traffic
// Description : Self-checking bench for car_traffic with small timing
//               parameters. A behavioural model tracks, per lane, the clocks
//               remaining until its next move, the level and the remaining
//               pause length; outputs are compared on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_car_traffic;

    localparam int BASE  = 8;
    localparam int LSTEP = 2;
    localparam int MINP  = 4;
    localparam int HIT   = 5;
    localparam int STEPX = 2;
    localparam int MAXL  = 9;
    localparam int XMAX  = 640 - 32;
    localparam int INIT [8] = '{606, 1, 607, 0, 200, 350, 420, 64};

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       score_pulse, hit_pulse, game_reset;
    logic [9:0] car_x1, car_x2, car_x3, car_x4, car_x5, car_x6, car_x7, car_x8;
    logic [3:0] level;
    logic       paused;
    logic [9:0] dut_x [8];

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model state
    int m_x [8];
    int m_rem [8];        // running clocks left until the lane moves
    int m_level;
    int m_pause_left;     // clocks of freeze still to go

    always #5 CLK = ~CLK;

    car_traffic #(
        .H_DISPLAY(640), .CAR_WIDTH(32), .STEP(STEPX),
        .BASE_PERIOD(BASE), .LEVEL_STEP(LSTEP), .MIN_PERIOD(MINP),
        .MAX_LEVEL(MAXL), .HIT_PAUSE(HIT),
        .INIT_X1(10'd606), .INIT_X2(10'd1), .INIT_X3(10'd607), .INIT_X4(10'd0),
        .INIT_X5(10'd200), .INIT_X6(10'd350), .INIT_X7(10'd420), .INIT_X8(10'd64)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .score_pulse(score_pulse), .hit_pulse(hit_pulse), .game_reset(game_reset),
        .car_x1(car_x1), .car_x2(car_x2), .car_x3(car_x3), .car_x4(car_x4),
        .car_x5(car_x5), .car_x6(car_x6), .car_x7(car_x7), .car_x8(car_x8),
        .level(level), .paused(paused)
    );

    assign dut_x[0] = car_x1;
    assign dut_x[1] = car_x2;
    assign dut_x[2] = car_x3;
    assign dut_x[3] = car_x4;
    assign dut_x[4] = car_x5;
    assign dut_x[5] = car_x6;
    assign dut_x[6] = car_x7;
    assign dut_x[7] = car_x8;

    function automatic int period_of(int l);
        int p;
        p = BASE - l * LSTEP;
        return (p < MINP) ? MINP : p;
    endfunction

    // Lane index 0 is lane 1 (rightward); odd indices travel left.
    function automatic int move(int idx, int x);
        if (idx % 2 == 0) return (x + STEPX > XMAX) ? 0 : x + STEPX;
        return (x < STEPX) ? XMAX : x - STEPX;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_x[i]   = INIT[i];
            m_rem[i] = BASE;
        end
        m_level      = 0;
        m_pause_left = 0;
    endtask

    task automatic model_step(input bit s, input bit h, input bit g);
        if (g) begin
            model_reset();
        end else begin
            if (m_pause_left == 0) begin
                for (int i = 0; i < 8; i++) begin
                    if (m_rem[i] == 1) begin
                        m_x[i]   = move(i, m_x[i]);
                        m_rem[i] = period_of(m_level);
                    end else begin
                        m_rem[i] = m_rem[i] - 1;
                    end
                end
            end
            if (h) m_pause_left = HIT;
            else if (m_pause_left > 0) m_pause_left = m_pause_left - 1;
            if (s && m_level < MAXL) m_level = m_level + 1;
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock with the given pulses; the model advances on the same edge.
    task automatic tick(input bit s, input bit h, input bit g);
        score_pulse = s;
        hit_pulse   = h;
        game_reset  = g;
        @(posedge CLK);
        model_step(s, h, g);
        #1;
        score_pulse = 1'b0;
        hit_pulse   = 1'b0;
        game_reset  = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (chk_en && RST_N) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("car_x%0d", i + 1), int'(dut_x[i]), m_x[i]);
            end
            check("level", int'(level), m_level);
            check("paused", int'(paused), (m_pause_left > 0) ? 1 : 0);
        end
    end

    initial begin
        int n;
        int prev;
        RST_N       = 1'b0;
        score_pulse = 1'b0;
        hit_pulse   = 1'b0;
        game_reset  = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N  = 1'b1;
        chk_en = 1'b1;

        // Reset state and first ticks, including both wrap directions
        check("rst_x1", int'(car_x1), 606);
        check("rst_x2", int'(car_x2), 1);
        check("rst_level", int'(level), 0);
        check("rst_paused", int'(paused), 0);
        repeat (7) tick(0, 0, 0);
        check("pre_tick_x1", int'(car_x1), 606);
        tick(0, 0, 0);
        check("tick1_x1", int'(car_x1), 608);
        check("tick1_x2_wrap", int'(car_x2), 608);
        check("tick1_x3_wrap", int'(car_x3), 0);
        check("tick1_x4_wrap", int'(car_x4), 608);
        repeat (8) tick(0, 0, 0);
        check("tick2_x1_wrap", int'(car_x1), 0);
        check("tick2_x2", int'(car_x2), 606);

        // Level rises and saturates; at level 9 each lane moves every 4 clks
        repeat (3) tick(1, 0, 0);
        check("level3", int'(level), 3);
        repeat (12) tick(1, 0, 0);
        check("level_sat", int'(level), 9);
        repeat (8) tick(0, 0, 0);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            prev = int'(car_x1);
            tick(0, 0, 0);
            if (int'(car_x1) != prev) n++;
        end
        check("ticks_in_40_at_l9", n, 10);

        // Single hit: 5 paused clocks; second hit 3 clks later extends it
        tick(0, 1, 0);
        n = int'(paused);
        repeat (11) begin tick(0, 0, 0); n += int'(paused); end
        check("pause_len", n, 5);
        tick(0, 1, 0);
        n = int'(paused);
        repeat (2) begin tick(0, 0, 0); n += int'(paused); end
        tick(0, 1, 0);
        n += int'(paused);
        repeat (11) begin tick(0, 0, 0); n += int'(paused); end
        check("pause_ext_len", n, 8);

        // game_reset wins over simultaneous hit and score
        tick(0, 1, 0);
        tick(1, 1, 1);
        check("gr_level", int'(level), 0);
        check("gr_paused", int'(paused), 0);
        check("gr_x1", int'(car_x1), 606);
        check("gr_x8", int'(car_x8), 64);

        // Async reset mid-pause takes effect before the next edge
        repeat (10) tick(1, 0, 0);
        tick(0, 1, 0);
        tick(0, 0, 0);
        #3;
        RST_N = 1'b0;
        #1;
        check("arst_paused", int'(paused), 0);
        check("arst_level", int'(level), 0);
        check("arst_x1", int'(car_x1), 606);
        check("arst_x2", int'(car_x2), 1);
        chk_en = 1'b0;
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RST_N  = 1'b1;
        chk_en = 1'b1;

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            tick($urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 299) == 0);
        end
        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_car_traffic
`default_nettype wire
